// File: rtl/dds_pkg.sv
// Shared constants, register-select encodings and the amplitude scaler for the
// two-channel DDS ROM scheduler.
package dds_pkg;

    localparam int ACC_W       = 32;
    localparam int ADDR_W      = 14;
    localparam int DATA_W      = 8;
    localparam int WSEL_W      = 2;
    localparam int TW          = ADDR_W - WSEL_W;
    localparam int CTRL_W      = 4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_WS_LSB = 1;
    localparam int CTRL_SYNC   = 3;

    localparam logic [DATA_W-1:0] AMP_RST = 8'hFF;

    typedef enum logic [1:0] {
        SEL_FREQ = 2'd0,
        SEL_OFFS = 2'd1,
        SEL_CTRL = 2'd2,
        SEL_AMP  = 2'd3
    } cfg_sel_e;

    typedef enum logic {
        SLOT_CH0 = 1'b0,
        SLOT_CH1 = 1'b1
    } slot_e;

    // (din * (amp+1)) >> 8, so amp=0xFF passes the table value through unchanged.
    function automatic logic [DATA_W-1:0] amp_scale(input logic [DATA_W-1:0] din,
                                                    input logic [DATA_W-1:0] amp);
        logic [2*DATA_W:0] prod;
        prod = {9'd0, din} * ({9'd0, amp} + 17'd1);
        return prod[2*DATA_W-1:DATA_W];
    endfunction

endpackage

// File: rtl/dds_chan_regs.sv
// One DDS channel: shadow/active configuration, phase accumulator, commit
// pending flag and wave-table address generation.
module dds_chan_regs
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [1:0]        sel,
    input  logic [ACC_W-1:0]  wdata,
    input  logic              commit,
    input  logic              slot_act,
    output logic              pending,
    output logic              issue,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] amp
);

    logic [ACC_W-1:0]  freq_s_q, freq_s_d, freq_a_q, freq_a_d;
    logic [TW-1:0]     offs_s_q, offs_s_d, offs_a_q, offs_a_d;
    logic [CTRL_W-1:0] ctrl_s_q, ctrl_s_d, ctrl_a_q, ctrl_a_d;
    logic [DATA_W-1:0] amp_s_q, amp_s_d, amp_a_q, amp_a_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              pending_q, pending_d;
    logic              service;
    logic [TW-1:0]     phase;

    // Next-state for shadow writes, commit bubble and accumulator stepping.
    always_comb begin
        freq_s_d  = freq_s_q;
        offs_s_d  = offs_s_q;
        ctrl_s_d  = ctrl_s_q;
        amp_s_d   = amp_s_q;
        freq_a_d  = freq_a_q;
        offs_a_d  = offs_a_q;
        ctrl_a_d  = ctrl_a_q;
        amp_a_d   = amp_a_q;
        acc_d     = acc_q;

        service   = slot_act & pending_q;
        issue     = slot_act & ~pending_q & ctrl_a_q[CTRL_EN];
        phase     = acc_q[ACC_W-1 -: TW] + offs_a_q;
        addr      = {ctrl_a_q[CTRL_WS_LSB +: WSEL_W], phase};
        amp       = amp_a_q;
        pending   = pending_q;

        if (wr) begin
            case (cfg_sel_e'(sel))
                SEL_FREQ: freq_s_d = wdata;
                SEL_OFFS: offs_s_d = wdata[TW-1:0];
                SEL_CTRL: ctrl_s_d = wdata[CTRL_W-1:0];
                SEL_AMP:  amp_s_d  = wdata[DATA_W-1:0];
                default:  freq_s_d = freq_s_q;
            endcase
        end else begin
            freq_s_d = freq_s_q;
        end

        // The bubble slot copies the pre-edge shadow; a same-cycle write re-arms via commit.
        if (service) begin
            freq_a_d = freq_s_q;
            offs_a_d = offs_s_q;
            ctrl_a_d = ctrl_s_q;
            amp_a_d  = amp_s_q;
            acc_d    = ctrl_s_q[CTRL_SYNC] ? {ACC_W{1'b0}} : acc_q;
        end else if (issue) begin
            acc_d    = acc_q + freq_a_q;
        end else begin
            acc_d    = acc_q;
        end

        pending_d = (pending_q & ~service) | commit;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_s_q  <= {ACC_W{1'b0}};
            offs_s_q  <= {TW{1'b0}};
            ctrl_s_q  <= {CTRL_W{1'b0}};
            amp_s_q   <= AMP_RST;
            freq_a_q  <= {ACC_W{1'b0}};
            offs_a_q  <= {TW{1'b0}};
            ctrl_a_q  <= {CTRL_W{1'b0}};
            amp_a_q   <= AMP_RST;
            acc_q     <= {ACC_W{1'b0}};
            pending_q <= 1'b0;
        end else begin
            freq_s_q  <= freq_s_d;
            offs_s_q  <= offs_s_d;
            ctrl_s_q  <= ctrl_s_d;
            amp_s_q   <= amp_s_d;
            freq_a_q  <= freq_a_d;
            offs_a_q  <= offs_a_d;
            ctrl_a_q  <= ctrl_a_d;
            amp_a_q   <= amp_a_d;
            acc_q     <= acc_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/dds_rom_sched.sv
// Two-channel DDS front end sharing one wave-table ROM: slot arbiter, address
// register, channel-tagged read pipeline and per-channel amplitude scaling.
module dds_rom_sched
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic              cfg_ch,
    input  logic [1:0]        cfg_sel,
    input  logic [ACC_W-1:0]  cfg_wdata,
    input  logic              cfg_commit,
    output logic [1:0]        cfg_busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd_data,
    output logic [DATA_W-1:0] ch0_data,
    output logic              ch0_valid,
    output logic [DATA_W-1:0] ch1_data,
    output logic              ch1_valid
);

    slot_e             slot_q, slot_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              iss_vld_q, iss_vld_d, iss_ch_q, iss_ch_d;
    logic              tag_vld_q, tag_vld_d, tag_ch_q, tag_ch_d;
    logic [DATA_W-1:0] ch0_data_q, ch0_data_d, ch1_data_q, ch1_data_d;
    logic              ch0_valid_q, ch0_valid_d, ch1_valid_q, ch1_valid_d;

    logic [1:0]        wr_en, commit_en, slot_act, pend, issue;
    logic [ADDR_W-1:0] ch_addr [2];
    logic [DATA_W-1:0] ch_amp  [2];
    logic [DATA_W-1:0] scaled;

    for (genvar g = 0; g < 2; g++) begin : g_chan
        dds_chan_regs u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr       (wr_en[g]),
            .sel      (cfg_sel),
            .wdata    (cfg_wdata),
            .commit   (commit_en[g]),
            .slot_act (slot_act[g]),
            .pending  (pend[g]),
            .issue    (issue[g]),
            .addr     (ch_addr[g]),
            .amp      (ch_amp[g])
        );
    end

    // Slot steering, address mux and the issue -> tag -> sample pipeline.
    always_comb begin
        wr_en     = {cfg_wr & cfg_ch, cfg_wr & ~cfg_ch};
        commit_en = {cfg_commit & cfg_ch, cfg_commit & ~cfg_ch};
        slot_act  = {slot_q == SLOT_CH1, slot_q == SLOT_CH0};
        slot_d    = (slot_q == SLOT_CH0) ? SLOT_CH1 : SLOT_CH0;

        iss_vld_d = |issue;
        iss_ch_d  = issue[1];
        if (|issue) begin
            rom_addr_d = issue[1] ? ch_addr[1] : ch_addr[0];
        end else begin
            rom_addr_d = rom_addr_q;
        end

        tag_vld_d   = iss_vld_q;
        tag_ch_d    = iss_ch_q;
        scaled      = amp_scale(rom_rd_data, tag_ch_q ? ch_amp[1] : ch_amp[0]);
        ch0_valid_d = tag_vld_q & ~tag_ch_q;
        ch1_valid_d = tag_vld_q & tag_ch_q;

        if (ch0_valid_d) begin
            ch0_data_d = scaled;
        end else begin
            ch0_data_d = ch0_data_q;
        end
        if (ch1_valid_d) begin
            ch1_data_d = scaled;
        end else begin
            ch1_data_d = ch1_data_q;
        end
    end

    // Scheduler and output registers; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= SLOT_CH0;
            rom_addr_q  <= {ADDR_W{1'b0}};
            iss_vld_q   <= 1'b0;
            iss_ch_q    <= 1'b0;
            tag_vld_q   <= 1'b0;
            tag_ch_q    <= 1'b0;
            ch0_data_q  <= {DATA_W{1'b0}};
            ch1_data_q  <= {DATA_W{1'b0}};
            ch0_valid_q <= 1'b0;
            ch1_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            rom_addr_q  <= rom_addr_d;
            iss_vld_q   <= iss_vld_d;
            iss_ch_q    <= iss_ch_d;
            tag_vld_q   <= tag_vld_d;
            tag_ch_q    <= tag_ch_d;
            ch0_data_q  <= ch0_data_d;
            ch1_data_q  <= ch1_data_d;
            ch0_valid_q <= ch0_valid_d;
            ch1_valid_q <= ch1_valid_d;
        end
    end

    assign cfg_busy  = pend;
    assign rom_addr  = rom_addr_q;
    assign ch0_data  = ch0_data_q;
    assign ch0_valid = ch0_valid_q;
    assign ch1_data  = ch1_data_q;
    assign ch1_valid = ch1_valid_q;

endmodule

// File: tb/tb_dds_rom_sched.sv
// Directed bench for dds_rom_sched with a 1-cycle-latency ROM model whose
// contents are addr[7:0]^0xC3 unless a constant override is enabled.
module tb_dds_rom_sched;
    import dds_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_wr = 1'b0;
    logic        cfg_ch = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic        cfg_commit = 1'b0;
    logic [1:0]  cfg_busy;
    logic [13:0] rom_addr;
    logic [7:0]  rom_rd_data = 8'h00;
    logic [7:0]  ch0_data, ch1_data;
    logic        ch0_valid, ch1_valid;
    logic        rom_ovr_en = 1'b0;
    logic [7:0]  rom_ovr = 8'h00;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_rd_data <= rom_ovr_en ? rom_ovr : (rom_addr[7:0] ^ 8'hC3);

    dds_rom_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_sel     (cfg_sel),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .cfg_busy    (cfg_busy),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data),
        .ch0_data    (ch0_data),
        .ch0_valid   (ch0_valid),
        .ch1_data    (ch1_data),
        .ch1_valid   (ch1_valid)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic ch, input logic [1:0] sel, input logic [31:0] data,
                       input logic commit);
        cfg_ch     = ch;
        cfg_sel    = sel;
        cfg_wdata  = data;
        cfg_wr     = 1'b1;
        cfg_commit = commit;
        tick(1);
        cfg_wr     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic wait_busy_clear(input int ch);
        int n = 0;
        while (cfg_busy[ch] && n < 16) begin
            tick(1);
            n++;
        end
        chk("busy_clear", 32'(cfg_busy[ch]), 32'd0);
    endtask

    task automatic wait_ch0_valid();
        int n = 0;
        while (!ch0_valid && n < 4) begin
            tick(1);
            n++;
        end
        chk("ch0_valid_seen", 32'(ch0_valid), 32'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_valids", 32'({ch0_valid, ch1_valid}), 32'h0);
        chk("rst_busy", 32'(cfg_busy), 32'h0);
        chk("rst_ch0_data", 32'(ch0_data), 32'h0);
        tick(2);
        rst_n = 1'b1;

        // ch0 basic sweep
        cfg(1'b0, SEL_FREQ, 32'h0010_0000, 1'b0);
        cfg(1'b0, SEL_CTRL, 32'h0000_0001, 1'b1);
        chk("t1_busy", 32'(cfg_busy), 32'h1);
        wait_busy_clear(0);
        tick(2);
        chk("t1_addr0", 32'(rom_addr), 32'h000);
        chk("t1_no_valid_yet", 32'(ch0_valid), 32'd0);
        tick(2);
        chk("t1_addr1", 32'(rom_addr), 32'h001);
        chk("t1_valid0", 32'(ch0_valid), 32'd1);
        chk("t1_data0", 32'(ch0_data), 32'hC3);
        tick(1);
        chk("t1_valid_gap", 32'(ch0_valid), 32'd0);
        tick(1);
        chk("t1_addr2", 32'(rom_addr), 32'h002);
        chk("t1_data1", 32'(ch0_data), 32'hC2);

        // ch1 wave_sel=2 with offset wrap
        cfg(1'b1, SEL_FREQ, 32'h0010_0000, 1'b0);
        cfg(1'b1, SEL_OFFS, 32'h0000_0FFF, 1'b0);
        cfg(1'b1, SEL_CTRL, 32'h0000_0005, 1'b1);
        chk("t2_busy", 32'(cfg_busy), 32'h2);
        wait_busy_clear(1);
        tick(2);
        chk("t2_addr_2fff", 32'(rom_addr), 32'h2FFF);
        tick(2);
        chk("t2_addr_2000", 32'(rom_addr), 32'h2000);
        chk("t2_ch1_valid", 32'(ch1_valid), 32'd1);
        chk("t2_ch1_data", 32'(ch1_data), 32'h3C);
        chk("t2_excl_ch0", 32'(ch0_valid), 32'd0);
        tick(1);
        chk("t2_ch0_valid", 32'(ch0_valid), 32'd1);
        chk("t2_excl_ch1", 32'(ch1_valid), 32'd0);
        tick(1);
        chk("t2_addr_2001", 32'(rom_addr), 32'h2001);
        chk("t2_ch1_data2", 32'(ch1_data), 32'hC3);

        // amplitude scaling
        rom_ovr    = 8'hFF;
        rom_ovr_en = 1'b1;
        cfg(1'b0, SEL_AMP, 32'h0000_007F, 1'b1);
        chk("t3_busy", 32'(cfg_busy[0]), 32'd1);
        wait_busy_clear(0);
        tick(6);
        wait_ch0_valid();
        chk("t3_amp7f", 32'(ch0_data), 32'h7F);
        rom_ovr = 8'hA5;
        cfg(1'b0, SEL_AMP, 32'h0000_00FF, 1'b1);
        wait_busy_clear(0);
        tick(6);
        wait_ch0_valid();
        chk("t3_ampff", 32'(ch0_data), 32'hA5);
        rom_ovr = 8'hFF;
        cfg(1'b0, SEL_AMP, 32'h0000_0000, 1'b1);
        wait_busy_clear(0);
        tick(6);
        wait_ch0_valid();
        chk("t3_amp00", 32'(ch0_data), 32'h00);
        chk("t3_ch1_ff", 32'(ch1_data), 32'hFF);

        // half-scale frequency, shadow write without commit
        cfg(1'b0, SEL_FREQ, 32'h8000_0000, 1'b0);
        cfg(1'b0, SEL_CTRL, 32'h0000_0009, 1'b1);
        wait_busy_clear(0);
        tick(2);
        chk("t4_addr_000a", 32'(rom_addr), 32'h000);
        tick(2);
        chk("t4_addr_800a", 32'(rom_addr), 32'h800);
        cfg(1'b0, SEL_FREQ, 32'h0010_0000, 1'b0);
        tick(1);
        chk("t4_addr_000b", 32'(rom_addr), 32'h000);
        tick(2);
        chk("t4_addr_800b", 32'(rom_addr), 32'h800);

        // write+commit same cycle carrying sync_clr
        cfg(1'b0, SEL_OFFS, 32'h0000_0123, 1'b0);
        cfg(1'b0, SEL_CTRL, 32'h0000_0001, 1'b0);
        cfg(1'b0, SEL_CTRL, 32'h0000_0009, 1'b1);
        chk("t5_busy", 32'(cfg_busy[0]), 32'd1);
        wait_busy_clear(0);
        chk("t5_valid_before", 32'(ch0_valid), 32'd1);
        tick(2);
        chk("t5_addr_123", 32'(rom_addr), 32'h123);
        chk("t5_missing_valid", 32'(ch0_valid), 32'd0);
        tick(2);
        chk("t5_addr_124", 32'(rom_addr), 32'h124);
        chk("t5_valid_back", 32'(ch0_valid), 32'd1);
        tick(2);
        chk("t5_addr_125", 32'(rom_addr), 32'h125);

        // reset mid-stream
        rst_n = 1'b0;
        #1;
        chk("t6_rom_addr", 32'(rom_addr), 32'h0);
        chk("t6_valids", 32'({ch0_valid, ch1_valid}), 32'h0);
        chk("t6_ch1_data", 32'(ch1_data), 32'h0);
        chk("t6_ch0_data", 32'(ch0_data), 32'h0);
        chk("t6_busy", 32'(cfg_busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t6_hold_valids", 32'({ch0_valid, ch1_valid}), 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t6_idle_valids", 32'({ch0_valid, ch1_valid}), 32'h0);
        end
        chk("t6_idle_addr", 32'(rom_addr), 32'h0);
        rom_ovr_en = 1'b0;
        cfg(1'b0, SEL_FREQ, 32'h0030_0000, 1'b0);
        cfg(1'b0, SEL_CTRL, 32'h0000_0001, 1'b1);
        chk("t6_busy_new", 32'(cfg_busy), 32'h1);
        wait_busy_clear(0);
        tick(2);
        chk("t6_addr0", 32'(rom_addr), 32'h000);
        chk("t6_no_valid", 32'(ch0_valid), 32'd0);
        tick(2);
        chk("t6_addr3", 32'(rom_addr), 32'h003);
        chk("t6_valid", 32'(ch0_valid), 32'd1);
        chk("t6_data", 32'(ch0_data), 32'hC3);
        chk("t6_ch1_quiet", 32'(ch1_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_rom_sched.md
Name: dds_rom_sched

Overview:
- Two-channel DDS controller that time-multiplexes one single-port synchronous wave-table ROM (16384x8, 1-cycle read latency, no output register).
- Each channel has a phase accumulator, phase offset, waveform select and amplitude scale.
- Channel 0 owns even slots and channel 1 owns odd slots, so each channel produces one sample every 2 clocks.
- Sits between the register/config front end and the DAC output path.

Parameters:
ACC_W, 32, phase accumulator / frequency word width
ADDR_W, 14, ROM address width
DATA_W, 8, ROM data and output sample width (unsigned, offset binary)
WSEL_W, 2, waveform select bits; table width TW = ADDR_W-WSEL_W = 12

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_wr  in  1  shadow-register write strobe
cfg_ch  in  1  target channel for cfg_wr / cfg_commit
cfg_sel  in  2  register select: 0 freq, 1 phase offset, 2 control, 3 amplitude
cfg_wdata  in  32  write data
cfg_commit  in  1  request shadow->active transfer for cfg_ch
cfg_busy  out  2  per-channel commit pending
rom_addr  out  ADDR_W  ROM address
rom_rd_data  in  DATA_W  ROM read data (valid 1 cycle after address)
ch0_data  out  DATA_W  channel 0 sample
ch0_valid  out  1  channel 0 sample strobe
ch1_data  out  DATA_W  channel 1 sample
ch1_valid  out  1  channel 1 sample strobe

Behaviour:
- Reset (async, rst_n low): slot=0, all accumulators 0, pending 0, outputs 0.
  - Shadow and active registers: freq=0, offset=0, ctrl=0, amp=0xFF.
  - rom_addr=0, valids=0.
- Slot: toggles every clk; slot=0 serves ch0. The first cycle after reset release is a ch0 slot.
- Registers per channel, shadow and active copies:
  - freq[31:0]
  - offset[11:0] (cfg_wdata[11:0])
  - ctrl: bit0 enable, bits[2:1] wave_sel, bit3 sync_clr
  - amp[7:0]
- cfg_wr writes the shadow copy only, same cycle; always accepted. Active registers change only at commit.
- Commit:
  - cfg_commit sets pending[cfg_ch]; cfg_busy = pending.
  - Pending is serviced at the next slot of that channel strictly after the commit cycle. That slot is a bubble: active <= shadow, acc <= 0 if shadow sync_clr else hold, pending cleared, no sample issued.
  - cfg_wr and cfg_commit to the same channel in the same cycle: the write is included in the commit.
  - cfg_commit while already pending: stays pending, single transfer.
- Issue (channel c slot, not pending, active enable=1):
  - rom_addr = {wave_sel, acc[31:20] + offset} (12-bit add, wraps mod 4096).
  - acc <= acc + freq (mod 2^32).
- Disabled channel: acc holds, no issue, rom_addr holds, no valid, chX_data holds its last value.
- Pipeline per sample, issue at cycle t:
  - t+1: rom_rd_data captured with channel tag.
  - t+2: chX_data = (rom_data * (amp+1)) >> 8, registered; chX_valid pulses 1 cycle.
  - amp=0xFF gives identity; product is 17 bits, keep bits [15:8].
- Latency: address at t -> sample valid at t+2. ch0_valid and ch1_valid are never high in the same cycle.
- The first issued sample after reset or sync_clr uses phase 0 (+offset).
- Reset mid-operation: in-flight samples are discarded; no valid after rst_n is asserted.

Decomposition:
- Shared package dds_pkg:
  - cfg_sel encodings (SEL_FREQ=0, SEL_OFFS=1, SEL_CTRL=2, SEL_AMP=3)
  - ctrl bit positions
  - TW constant
  - reset default AMP_RST=0xFF
- One sub-module: dds_chan_regs, instantiated twice. It holds the shadow/active registers, accumulator, pending flag and address generation; the top holds slot, ROM mux, pipeline tag and scaler.

Test Plan:
- ch0 freq=0x00100000, ctrl=0x1, commit -> after bubble, ch0 rom_addr 0x000,0x001,0x002 on even cycles; ch0_valid every 2 clks, 2 cycles after each address.
- ch1 wave_sel=2, offset=0xFFF, freq=0x00100000 -> rom_addr 0x2FFF, 0x2000, 0x2001 (offset wrap within table).
- amp=0x7F, ROM returns 0xFF -> ch0_data=0x7F; amp=0xFF, ROM returns 0xA5 -> 0xA5; amp=0x00, ROM returns 0xFF -> 0x00.
- freq=0x80000000 -> addresses alternate 0x000,0x800; accumulator wraps with no glitch; cfg_wr freq without commit -> sequence unchanged.
- cfg_wr+cfg_commit same cycle with sync_clr=1 during a running ch0 -> cfg_busy[0]=1 until ch0 slot, one missing ch0_valid, then addresses restart at offset.
- rst_n low mid-stream with both channels enabled -> all outputs 0 immediately, no valid afterward; after release ch0 issues first only after a new enable+commit.
